// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: sign/zero extension to full word or slot splat.
// Optional IMM_EXT_SHL_EN adds a shl16 input that shifts the extended value left by 16.
module imm_extend_pipe #(
  parameter int OUT_W  = 128,
  parameter int SLOT_W = 32,
  parameter int IMM_W  = 18,
  parameter int W0     = 7,
  parameter int W1     = 10,
  parameter int W2     = 16,
  parameter int W3     = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        fmt,
  input  logic [1:0]        mode,
`ifdef IMM_EXT_SHL_EN
  input  logic              shl16,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out
);

  localparam int REP = OUT_W / SLOT_W;
  localparam int PW  = (IMM_W > SLOT_W) ? IMM_W : SLOT_W;

  function automatic int width_of(input logic [1:0] f);
    int w;
    case (f)
      2'd0:    w = W0;
      2'd1:    w = W1;
      2'd2:    w = W2;
      default: w = W3;
    endcase
    return w;
  endfunction

  function automatic logic [SLOT_W-1:0] slot_mask(input int w);
    logic [SLOT_W-1:0] m;
    for (int i = 0; i < SLOT_W; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] word_mask(input int w);
    logic [OUT_W-1:0] m;
    for (int i = 0; i < OUT_W; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [SLOT_W-1:0] field_q, field_d;
  logic [1:0]        fmt_q, fmt_d;
  logic [1:0]        mode_q, mode_d;
`ifdef IMM_EXT_SHL_EN
  logic              shl_q, shl_d;
`endif
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_q, out_d;

  logic              adv1, adv2, accept;
  logic [PW-1:0]     imm_pad;
  logic [SLOT_W-1:0] fld_in;
  int                w_in, w_s1;
  logic              sgn, fill;
  logic [SLOT_W-1:0] slot;
  logic [OUT_W-1:0]  wide, ext;

  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = reset && adv1;
    accept   = in_valid && in_ready;
  end

  // Field is masked at capture so stage 2 only sees the selected bits
  always_comb begin
    w_in    = width_of(fmt);
    imm_pad = PW'(imm);
    fld_in  = imm_pad[SLOT_W-1:0] & slot_mask(w_in);
  end

  always_comb begin
    w_s1 = width_of(fmt_q);
    sgn  = 1'b0;
    for (int i = 0; i < SLOT_W; i++) begin
      if (i == w_s1 - 1) sgn = field_q[i];
    end
    fill = sgn && !mode_q[0];
    slot = field_q | (fill ? ~slot_mask(w_s1) : '0);
    wide = OUT_W'(field_q) | (fill ? ~word_mask(w_s1) : '0);
`ifdef IMM_EXT_SHL_EN
    if (shl_q) begin
      slot = slot << 16;
      wide = wide << 16;
    end
`endif
    ext = mode_q[1] ? {REP{slot}} : wide;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    field_d    = field_q;
    fmt_d      = fmt_q;
    mode_d     = mode_q;
`ifdef IMM_EXT_SHL_EN
    shl_d      = shl_q;
`endif
    if (adv1) begin
      s1_valid_d = accept;
      if (accept) begin
        field_d = fld_in;
        fmt_d   = fmt;
        mode_d  = mode;
`ifdef IMM_EXT_SHL_EN
        shl_d   = shl16;
`endif
      end
    end
  end

  // Result is held after a pop; only a stage-2 load changes it
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_d = ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      field_q     <= '0;
      fmt_q       <= '0;
      mode_q      <= '0;
`ifdef IMM_EXT_SHL_EN
      shl_q       <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      field_q     <= field_d;
      fmt_q       <= fmt_d;
      mode_q      <= mode_d;
`ifdef IMM_EXT_SHL_EN
      shl_q       <= shl_d;
`endif
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed table-driven bench for imm_extend_pipe plus handshake corner sequences.
module tb_imm_extend_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [17:0]  imm;
  logic [1:0]   fmt;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
`ifdef IMM_EXT_SHL_EN
  logic         shl16;
`endif

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .fmt       (fmt),
    .mode      (mode),
`ifdef IMM_EXT_SHL_EN
    .shl16     (shl16),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  typedef struct {
    logic [1:0]   fmt;
    logic [1:0]   mode;
    logic [17:0]  imm;
    logic [127:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int k;
  logic last_acc;
  logic [127:0] got [$];
  int acc_cyc [$];
  int pop_cyc [$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Samples handshakes mid-cycle, then advances to the next negedge
  task automatic cycle();
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      got.push_back(out);
      pop_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clr();
    got.delete();
    acc_cyc.delete();
    pop_cyc.delete();
  endtask

  function automatic logic [127:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 'x;
  endfunction

  function automatic int first_lat();
    if (pop_cyc.size() > 0 && acc_cyc.size() > 0)
      return pop_cyc[0] - acc_cyc[0];
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'd0, 2'd0, 18'h0005D,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDD};
    vecs[1]  = '{2'd0, 2'd1, 18'h0005D, 128'h5D};
    vecs[2]  = '{2'd1, 2'd0, 18'h002AA,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FEAA};
    vecs[3]  = '{2'd0, 2'd0, 18'h3FF80, 128'h0};
    vecs[4]  = '{2'd2, 2'd2, 18'h08001,
                 128'hFFFF8001_FFFF8001_FFFF8001_FFFF8001};
    vecs[5]  = '{2'd2, 2'd3, 18'h08001,
                 128'h00008001_00008001_00008001_00008001};
    vecs[6]  = '{2'd3, 2'd0, 18'h3FFFF, {128{1'b1}}};
    vecs[7]  = '{2'd3, 2'd2, 18'h20000,
                 128'hFFFE0000_FFFE0000_FFFE0000_FFFE0000};
    vecs[8]  = '{2'd1, 2'd1, 18'h003FF, 128'h3FF};
    vecs[9]  = '{2'd0, 2'd3, 18'h3FFC0,
                 128'h00000040_00000040_00000040_00000040};
    vecs[10] = '{2'd2, 2'd0, 18'h07FFF, 128'h7FFF};
    vecs[11] = '{2'd0, 2'd2, 18'h0007F, {128{1'b1}}};

    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    imm = '0;
    fmt = '0;
    mode = '0;
`ifdef IMM_EXT_SHL_EN
    shl16 = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out", out, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      clr();
      fmt = vecs[i].fmt;
      mode = vecs[i].mode;
      imm = vecs[i].imm;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_early", i), 128'(out_valid), 128'd0);
      cycle();
      cycle();
      chk($sformatf("vec%0d_cnt", i), 128'(got.size()), 128'd1);
      chk($sformatf("vec%0d_out", i), got_at(0), vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 128'(first_lat()), 128'd2);
    end

    clr();
    out_ready = 1'b0;
    fmt = 2'd3;
    mode = 2'd1;
    k = 1;
    for (int c = 0; c < 6; c++) begin
      imm = 18'(k);
      in_valid = (k <= 3);
      cycle();
      if (last_acc) k++;
    end
    #1;
    chk("bp_accepts", 128'(acc_cyc.size()), 128'd2);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    chk("bp_out_hold", out, 128'h1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      imm = 18'(k);
      in_valid = (k <= 3);
      cycle();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("bp_total_acc", 128'(acc_cyc.size()), 128'd3);
    chk("bp_count", 128'(got.size()), 128'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_out%0d", i), got_at(i), 128'(i + 1));

    clr();
    out_ready = 1'b1;
    fmt = 2'd3;
    mode = 2'd1;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      imm = 18'(16 + k);
      in_valid = (k < 8);
      cycle();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    chk("tp_acc_cnt", 128'(acc_cyc.size()), 128'd8);
    chk("tp_pop_cnt", 128'(got.size()), 128'd8);
    chk("tp_first_lat", 128'(first_lat()), 128'd2);
    if (acc_cyc.size() == 8 && pop_cyc.size() == 8) begin
      chk("tp_acc_span", 128'(acc_cyc[7] - acc_cyc[0]), 128'd7);
      chk("tp_pop_span", 128'(pop_cyc[7] - pop_cyc[0]), 128'd7);
    end else begin
      chk("tp_spans", 128'(pop_cyc.size()), 128'd8);
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("tp_out%0d", i), got_at(i), 128'(16 + i));

    clr();
    out_ready = 1'b0;
    fmt = 2'd3;
    mode = 2'd1;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      imm = 18'(5 + k);
      in_valid = (k < 2);
      cycle();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    #1;
    chk("mr_full", 128'(in_ready), 128'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 128'(out_valid), 128'd0);
    chk("mr_out", out, 128'd0);
    chk("mr_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_rel_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    clr();
    out_ready = 1'b1;
    fmt = 2'd0;
    mode = 2'd0;
    imm = 18'h0007F;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("mr_count", 128'(got.size()), 128'd1);
    chk("mr_result", got_at(0), {128{1'b1}});
    chk("mr_lat", 128'(first_lat()), 128'd2);

`ifdef IMM_EXT_SHL_EN
    clr();
    fmt = 2'd2;
    mode = 2'd3;
    imm = 18'h01234;
    shl16 = 1'b1;
    in_valid = 1'b1;
    cycle();
    fmt = 2'd0;
    mode = 2'd0;
    imm = 18'h0005D;
    cycle();
    in_valid = 1'b0;
    shl16 = 1'b0;
    repeat (4) cycle();
    chk("shl_count", 128'(got.size()), 128'd2);
    chk("shl_splat", got_at(0),
        128'h12340000_12340000_12340000_12340000);
    chk("shl_wide", got_at(1),
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDD_0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender feeding the SPU operand path.
- Takes a raw instruction immediate field of one of four selectable widths.
- Produces a full-width register operand, either:
  - sign- or zero-extended across the whole word, or
  - extended to one slot width and replicated into every slot (splat).
- Valid/ready handshake on both sides; full throughput, fixed latency, stalls under back-pressure without loss.

Parameters:
- OUT_W, 128: output operand width; must be a multiple of SLOT_W.
- SLOT_W, 32: slot width used by splat modes.
- IMM_W, 18: width of the imm input port; must be >= every Wn.
- W0, 7: field width selected by fmt=0.
- W1, 10: field width selected by fmt=1.
- W2, 16: field width selected by fmt=2.
- W3, 18: field width selected by fmt=3.
- Constraint: every Wn satisfies 1 <= Wn <= SLOT_W.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- in_valid, input, 1: upstream presents a request.
- in_ready, output, 1: block accepts a request this cycle.
- imm, input, IMM_W: raw immediate; only imm[Wn-1:0] is used.
- fmt, input, 2: selects field width W0..W3.
- mode, input, 2: extension mode.
  - 00: sign-extend to OUT_W.
  - 01: zero-extend to OUT_W.
  - 10: sign-extend to SLOT_W, then splat.
  - 11: zero-extend to SLOT_W, then splat.
- out_valid, output, 1: out holds a valid result.
- out_ready, input, 1: downstream consumes out this cycle.
- out, output, OUT_W: extended operand.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, out=0, out_valid=0, in_ready=0.
  - Any in-flight requests are discarded immediately, independent of clk.
  - in_ready rises combinationally once reset=1.
- Pipeline structure:
  - Stage 1 registers: masked field, fmt, mode.
  - Stage 2 registers: out (the extended result) and out_valid.
- Advance rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational, no dependence on in_valid).
- Transfers:
  - Accept when in_valid && in_ready; captures imm[Wfmt-1:0] zero-padded, plus fmt and mode.
  - Stage 1 moves to stage 2 when s1_valid && adv2.
  - Output transfer when out_valid && out_ready.
- Latency and throughput:
  - Exactly 2 cycles from accept edge to out_valid, with no stall.
  - One result per cycle sustained when out_ready=1.
- Simultaneous events: accept, stage advance and output pop in the same cycle are all legal and all take effect. Order is strictly FIFO.
- Stall behaviour:
  - out and out_valid hold stable while out_valid && !out_ready.
  - Stage 1 holds while blocked.
  - Maximum 2 requests in flight; in_ready=0 when both stages are full and out_ready=0.
- Arithmetic rules (W = Wfmt, s = field[W-1]):
  - Mode 00: out = {(OUT_W-W){s}, field}.
  - Mode 01: out = {(OUT_W-W){0}, field}.
  - Modes 1x: slot = {(SLOT_W-W){s or 0}, field}, then out = slot replicated OUT_W/SLOT_W times.
- Boundary conditions:
  - imm bits at or above Wfmt are ignored (no error).
  - W = SLOT_W in splat mode: slot = field with no extension.
  - out changes only on a stage-2 load; it is not cleared on pop.

Optional Feature:
- Macro: IMM_EXT_SHL_EN.
- Defined:
  - Adds input port shl16 (1 bit), captured with the request at accept.
  - When shl16=1, the extended value is shifted left by 16 (ILHU-style) before splat or output. Vacated low bits are 0; bits shifted beyond OUT_W (or SLOT_W in splat modes) are discarded.
  - Latency and handshake are unchanged.
- Undefined: port absent; no shift logic; behaviour exactly as above.

Test Plan:
- Reset then fmt=0, imm=7'h5D:
  - mode=00 -> out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDD, out_valid exactly 2 cycles after accept.
  - mode=01 -> out=128'h5D.
- fmt=1, imm=10'h2AA, mode=00 -> out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FEAA. Then fmt=0, imm=18'h3FF80 (low 7 bits 0), mode=00 -> out=128'h0, proving upper imm bits are ignored.
- Splat: fmt=2, imm=16'h8001.
  - mode=10 -> out=128'hFFFF8001_FFFF8001_FFFF8001_FFFF8001.
  - mode=11 -> out=128'h00008001_00008001_00008001_00008001.
- Back-pressure:
  - Hold out_ready=0 and offer 3 requests (imm 1, 2, 3; fmt=3; mode=01) -> exactly 2 accepted, in_ready=0, out stable at 128'h1.
  - Release out_ready -> outputs 1, 2, 3 in order, no loss or duplication.
- Throughput: 8 back-to-back requests with out_ready=1 -> 8 results on 8 consecutive cycles, first one 2 cycles after the first accept.
- Reset mid-operation: assert reset=0 between clock edges with both stages full -> out_valid=0 and out=0 immediately. After release, the next accept yields a correct result with no stale outputs.
- With IMM_EXT_SHL_EN defined: fmt=2, imm=16'h1234, mode=11, shl16=1 -> out=128'h12340000_12340000_12340000_12340000.
